rtc_bus_sequencer: RTL and testbench

Parametrised bus-cycle sequencer for multiplexed address/data real-time-clock chips. Generates ChipSelect, Read, Write, AoD and drives or releases DATA_ADDRESS with programmable setup, strobe, hold and recovery times. Supports single writes, burst reads with address auto-increment, and an optional transfer-command cycle. It sits between the general control FSM (start/done handshake) and the RTC pins, and replaces per-signal glue logic with one owned timing engine.

---
 rtl/rtc_bus_sequencer_if.sv | 26 ++
 rtl/rtc_bus_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_sequencer_if.sv
// Start/done handshake between the control FSM and the RTC bus sequencer.
interface rtc_bus_sequencer_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 4
);
  logic          start;
  logic          write_en;
  logic          cmd_en;
  logic [DW-1:0] addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata;
  logic          rdata_valid;

  modport master (
    output start, write_en, cmd_en, addr, len, wdata,
    input  busy, done, rdata, rdata_valid
  );

  modport slave (
    input  start, write_en, cmd_en, addr, len, wdata,
    output busy, done, rdata, rdata_valid
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle timing engine for multiplexed address/data RTC chips.
// state | meaning
// IDLE  | waiting for start
// CMDC  | command cycle, bus = CMD, AoD=0, Write strobe
// ADDR  | address cycle, bus = current address, AoD=0, Write strobe
// RDAT  | read data cycle, bus released, AoD=1, Read strobe
// WDAT  | write data cycle, bus = wdata, AoD=1, Write strobe
// FIN   | one-cycle done pulse
module rtc_bus_sequencer #(
  parameter int unsigned   DW    = 8,
  parameter int unsigned   LW    = 4,
  parameter int unsigned   T_SU  = 2,
  parameter int unsigned   T_PW  = 8,
  parameter int unsigned   T_HD  = 2,
  parameter int unsigned   T_REC = 4,
  parameter logic [DW-1:0] CMD   = 'hF0
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_sequencer_if.slave ctl,
  output logic               ChipSelect,
  output logic               Read,
  output logic               Write,
  output logic               AoD,
  inout  wire  [DW-1:0]      DATA_ADDRESS
);
  localparam int unsigned TMAX_A = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int unsigned TMAX_B = (T_HD > T_REC) ? T_HD : T_REC;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int unsigned CW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] CNT_SU  = CW'(T_SU - 1);
  localparam logic [CW-1:0] CNT_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] CNT_HD  = CW'(T_HD - 1);
  localparam logic [CW-1:0] CNT_REC = CW'(T_REC - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMDC, S_ADDR, S_RDAT, S_WDAT, S_FIN} state_t;
  typedef enum logic [1:0] {P_SU, P_PW, P_HD, P_REC} phase_t;

  state_t        st_q, st_d;
  phase_t        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_write_q, is_write_d;
  logic          cmd_q, cmd_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cs_q, cs_d;
  logic          rstb_q, rstb_d;
  logic          wstb_q, wstb_d;
  logic          aod_q, aod_d;
  logic          bus_oe_q, bus_oe_d;
  logic [DW-1:0] bus_out_q, bus_out_d;
  logic          wr_kind, bus_kind;

  always_comb begin
    st_d       = st_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    unique case (st_q)
      S_IDLE: begin
        if (ctl.start) begin
          is_write_d = ctl.write_en;
          cmd_d      = ctl.cmd_en;
          addr_d     = ctl.addr;
          wdata_d    = ctl.wdata;
          rem_d      = (ctl.len == '0) ? LW'(1) : ctl.len;
          st_d       = (!ctl.write_en && ctl.cmd_en) ? S_CMDC : S_ADDR;
          ph_d       = P_SU;
          cnt_d      = CNT_SU;
        end
      end
      S_FIN: st_d = S_IDLE;
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          unique case (ph_q)
            P_SU: begin
              ph_d  = P_PW;
              cnt_d = CNT_PW;
            end
            P_PW: begin
              ph_d  = P_HD;
              cnt_d = CNT_HD;
              // read data is taken on the last strobe-low cycle
              if (st_q == S_RDAT) begin
                rdata_d  = DATA_ADDRESS;
                rvalid_d = 1'b1;
              end
            end
            P_HD: begin
              ph_d  = P_REC;
              cnt_d = CNT_REC;
            end
            default: begin
              ph_d  = P_SU;
              cnt_d = CNT_SU;
              unique case (st_q)
                S_CMDC: st_d = is_write_q ? S_FIN : S_ADDR;
                S_ADDR: st_d = is_write_q ? S_WDAT : S_RDAT;
                S_WDAT: st_d = cmd_q ? S_CMDC : S_FIN;
                default: begin
                  st_d   = (rem_q > LW'(1)) ? S_ADDR : S_FIN;
                  addr_d = addr_q + 1'b1;
                  rem_d  = rem_q - 1'b1;
                end
              endcase
            end
          endcase
        end
      end
    endcase

    // pin outputs are derived from the next state so they land registered
    wr_kind   = (st_d == S_CMDC) || (st_d == S_ADDR) || (st_d == S_WDAT);
    bus_kind  = wr_kind || (st_d == S_RDAT);
    cs_d      = !(bus_kind && (ph_d != P_REC));
    rstb_d    = !((st_d == S_RDAT) && (ph_d == P_PW));
    wstb_d    = !(wr_kind && (ph_d == P_PW));
    aod_d     = bus_kind ? ((st_d == S_WDAT) || (st_d == S_RDAT)) : aod_q;
    bus_oe_d  = wr_kind && (ph_d != P_REC);
    bus_out_d = (st_d == S_CMDC) ? CMD : ((st_d == S_ADDR) ? addr_d : wdata_d);
    busy_d    = (st_d != S_IDLE);
    done_d    = (st_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= S_IDLE;
      ph_q       <= P_SU;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b1;
      rstb_q     <= 1'b1;
      wstb_q     <= 1'b1;
      aod_q      <= 1'b1;
      bus_oe_q   <= 1'b0;
      bus_out_q  <= '0;
    end else begin
      st_q       <= st_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      rstb_q     <= rstb_d;
      wstb_q     <= wstb_d;
      aod_q      <= aod_d;
      bus_oe_q   <= bus_oe_d;
      bus_out_q  <= bus_out_d;
    end
  end

  assign DATA_ADDRESS    = bus_oe_q ? bus_out_q : {DW{1'bz}};
  assign ChipSelect      = cs_q;
  assign Read            = rstb_q;
  assign Write           = wstb_q;
  assign AoD             = aod_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;
  assign ctl.rdata       = rdata_q;
  assign ctl.rdata_valid = rvalid_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: table vectors, reset corner case and random transactions
// checked cycle by cycle against a bus-cycle list model with an RTC that returns addr^0x55.
module tb_rtc_bus_sequencer;
  localparam int TSU = 2, TPW = 8, THD = 2, TREC = 4;
  localparam int L = TSU + TPW + THD + TREC;
  localparam int K_CMDC = 0, K_ADDR = 1, K_WDAT = 2, K_RDAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs_n, rd_n, wr_n, aod;
  wire [7:0] data_address;

  rtc_bus_sequencer_if #(.DW(8), .LW(4)) ctl();

  rtc_bus_sequencer #(
    .DW(8), .LW(4), .T_SU(TSU), .T_PW(TPW), .T_HD(THD), .T_REC(TREC), .CMD(8'hF0)
  ) dut (
    .clk(clk), .reset(reset), .ctl(ctl),
    .ChipSelect(cs_n), .Read(rd_n), .Write(wr_n), .AoD(aod),
    .DATA_ADDRESS(data_address)
  );

  always #5 clk = ~clk;

  // RTC model: remembers the last byte written with AoD=0, answers reads with it ^ 0x55
  logic [7:0] rtc_addr = 8'h00;
  assign data_address = !rd_n ? (rtc_addr ^ 8'h55) : 8'hzz;
  always @(negedge clk) if (!wr_n && !aod) rtc_addr <= data_address;

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int c, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  int         m_kind[$];
  logic [7:0] m_val[$];

  task automatic build(input logic we, input logic ce, input logic [7:0] a,
                       input logic [3:0] ln, input logic [7:0] wd);
    int n;
    logic [7:0] ai;
    m_kind.delete();
    m_val.delete();
    if (we) begin
      m_kind.push_back(K_ADDR); m_val.push_back(a);
      m_kind.push_back(K_WDAT); m_val.push_back(wd);
      if (ce) begin m_kind.push_back(K_CMDC); m_val.push_back(8'hF0); end
    end else begin
      if (ce) begin m_kind.push_back(K_CMDC); m_val.push_back(8'hF0); end
      n = (ln == 0) ? 1 : int'(ln);
      for (int i = 0; i < n; i++) begin
        ai = a + 8'(i);
        m_kind.push_back(K_ADDR); m_val.push_back(ai);
        m_kind.push_back(K_RDAT); m_val.push_back(ai ^ 8'h55);
      end
    end
  endtask

  task automatic check_cycle(input int c);
    int nl, k, o, kd;
    logic strobe, active;
    logic [5:0] got, want;
    nl  = m_kind.size() * L;
    got = {ctl.busy, ctl.done, cs_n, rd_n, wr_n, ctl.rdata_valid};
    if (c <= nl) begin
      k = (c - 1) / L;
      o = (c - 1) % L;
      kd = m_kind[k];
      strobe = (o >= TSU) && (o < TSU + TPW);
      active = (o < TSU + TPW + THD);
      want = {1'b1, 1'b0, !active, !(strobe && kd == K_RDAT), !(strobe && kd != K_RDAT),
              (kd == K_RDAT) && (o == TSU + TPW)};
      chk("pins", c, 32'(got), 32'(want));
      chk("drive", c, 32'(dut.bus_oe_q), 32'(active && kd != K_RDAT));
      if (active && kd != K_RDAT) chk("bus", c, 32'(data_address), 32'(m_val[k]));
      if (active && o >= TSU) chk("aod", c, 32'(aod), 32'(kd == K_WDAT || kd == K_RDAT));
      if (kd == K_RDAT && o == TSU + TPW) chk("rdata", c, 32'(ctl.rdata), 32'(m_val[k]));
    end else if (c == nl + 1) begin
      chk("pins_fin", c, 32'(got), 32'(6'b111110));
      chk("drive_fin", c, 32'(dut.bus_oe_q), 32'(0));
    end else begin
      chk("pins_idle", c, 32'(got), 32'(6'b001110));
      chk("drive_idle", c, 32'(dut.bus_oe_q), 32'(0));
    end
  endtask

  task automatic run_txn(input logic we, input logic ce, input logic [7:0] a,
                         input logic [3:0] ln, input logic [7:0] wd,
                         input int stray_a, input int stray_b,
                         output int done_at, output int n_done,
                         output int n_valid, output logic [7:0] last_rd);
    int nl;
    build(we, ce, a, ln, wd);
    nl = m_kind.size() * L;
    @(negedge clk);
    ctl.start = 1'b1; ctl.write_en = we; ctl.cmd_en = ce;
    ctl.addr = a; ctl.len = ln; ctl.wdata = wd;
    done_at = 0; n_done = 0; n_valid = 0; last_rd = 8'h00;
    for (int c = 1; c <= nl + 2; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (ctl.done) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (ctl.rdata_valid) begin
        n_valid++;
        last_rd = ctl.rdata;
      end
      // latched inputs must be immune to later changes and stray starts
      ctl.start = (c == stray_a) || (c == stray_b);
      {ctl.write_en, ctl.cmd_en} = 2'($urandom);
      ctl.addr  = 8'($urandom);
      ctl.len   = 4'($urandom);
      ctl.wdata = 8'($urandom);
    end
    ctl.start = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic       ce;
    logic [7:0] a;
    logic [3:0] ln;
    logic [7:0] wd;
    int         s1;
    int         s2;
    int         exp_done;
    int         exp_valid;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int done_at, n_done, n_valid, cnt;
    logic [7:0] last_rd;

    vecs[0] = '{1'b1, 1'b0, 8'h21, 4'd0, 8'h45, 0, 0,  33, 0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'hFE, 4'd3, 8'h00, 0, 0, 113, 3, 8'h55};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 4'd0, 8'h99, 0, 0,  49, 0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'h40, 4'd0, 8'h00, 0, 0,  33, 1, 8'h15};
    vecs[4] = '{1'b0, 1'b0, 8'h33, 4'd1, 8'h00, 5, 33, 33, 1, 8'h66};
    vecs[5] = '{1'b0, 1'b0, 8'h7F, 4'd2, 8'h00, 0, 0,  65, 2, 8'hD5};

    ctl.start = 1'b0; ctl.write_en = 1'b0; ctl.cmd_en = 1'b0;
    ctl.addr = 8'h00; ctl.len = 4'd0; ctl.wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_pins", 0, 32'({ctl.busy, ctl.done, ctl.rdata_valid, cs_n, rd_n, wr_n, aod}),
        32'(7'b0001111));
    chk("reset_rdata", 0, 32'(ctl.rdata), 32'(0));
    chk("reset_drive", 0, 32'(dut.bus_oe_q), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].we, vecs[i].ce, vecs[i].a, vecs[i].ln, vecs[i].wd,
              vecs[i].s1, vecs[i].s2, done_at, n_done, n_valid, last_rd);
      chk($sformatf("v%0d_done_at", i), 0, 32'(done_at), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_n_done", i), 0, 32'(n_done), 32'(1));
      chk($sformatf("v%0d_n_valid", i), 0, 32'(n_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_last_rdata", i), 0, 32'(last_rd), 32'(vecs[i].exp_last));
    end

    // reset in the middle of a write: takes effect on the next edge, no done afterwards
    build(1'b1, 1'b0, 8'h21, 4'd0, 8'h45);
    @(negedge clk);
    ctl.start = 1'b1; ctl.write_en = 1'b1; ctl.cmd_en = 1'b0;
    ctl.addr = 8'h21; ctl.wdata = 8'h45;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_cycle(c);
      ctl.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_pins", 13, 32'({ctl.busy, ctl.done, cs_n, rd_n, wr_n, aod}), 32'(6'b001111));
    chk("rst_mid_drive", 13, 32'(dut.bus_oe_q), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ctl.done || ctl.busy) cnt++;
    end
    chk("rst_mid_quiet", 0, 32'(cnt), 32'(0));
    run_txn(1'b1, 1'b0, 8'h21, 4'd0, 8'h45, 0, 0, done_at, n_done, n_valid, last_rd);
    chk("rst_after_done_at", 0, 32'(done_at), 32'(33));
    chk("rst_after_n_done", 0, 32'(n_done), 32'(1));

    for (int i = 0; i < 24; i++) begin
      logic       we, ce;
      logic [7:0] a, wd, exp_last;
      logic [3:0] ln;
      int         exp_valid;
      we = 1'($urandom);
      ce = 1'($urandom);
      a  = (i % 4 == 0) ? 8'hFD : 8'($urandom);
      ln = 4'($urandom_range(0, 6));
      wd = 8'($urandom);
      exp_valid = we ? 0 : ((ln == 0) ? 1 : int'(ln));
      exp_last  = we ? 8'h00 : ((a + 8'(exp_valid - 1)) ^ 8'h55);
      run_txn(we, ce, a, ln, wd, $urandom_range(1, 20), $urandom_range(1, 20),
              done_at, n_done, n_valid, last_rd);
      chk("rnd_done_at", i, 32'(done_at), 32'(m_kind.size() * L + 1));
      chk("rnd_n_done", i, 32'(n_done), 32'(1));
      chk("rnd_n_valid", i, 32'(n_valid), 32'(exp_valid));
      if (exp_valid > 0) chk("rnd_last_rdata", i, 32'(last_rd), 32'(exp_last));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
